ex_alu: RTL and testbench
=========================

EX_ALU -- requirements
Module: ex_alu

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width; only 16 is supported.
REQ-002 Port: clock  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  reset, synchronous, active-high.
REQ-004 Port: start  in  1  issue request; sampled only while busy=0.
REQ-005 Port: alu_ctrl  in  3  operation code produced by the EX-stage ALU control block.
REQ-006 Port: op_a  in  16  first operand.
REQ-007 Port: op_b  in  16  second operand (shift amount in op_b[3:0] for shifts).
REQ-008 Port: result  out  16  registered result.
REQ-009 Port: zero  out  1  registered; 1 when result==0x0000.
REQ-010 Port: overflow  out  1  registered overflow flag.
REQ-011 Port: valid  out  1  one-cycle pulse marking new result/zero/overflow.
REQ-012 Port: busy  out  1  multi-cycle operation in progress; pipeline stall request.

Function
REQ-013 alu_ctrl encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed), 101 SLL, 110 SRL (logical), 111 MUL.
REQ-014 FSM SHALL have two states: IDLE (busy=0) and MUL (busy=1).
REQ-015 In IDLE, start=1 with alu_ctrl!=111 SHALL register result/zero/overflow at that edge and assert valid for exactly the next cycle (latency 1).
REQ-016 ADD/SUB: 16-bit two's-complement wrap; overflow = signed overflow (operands same sign for ADD / different sign for SUB, result sign differs).
REQ-017 AND, OR, SLT, SLL, SRL SHALL drive overflow=0; SLT result = 0x0001 if signed op_a<op_b else 0x0000.
REQ-018 Shifts SHALL use op_b[3:0] only; op_b[15:4] ignored.
REQ-019 In IDLE, start=1 with alu_ctrl=111 SHALL capture op_a, op_b, clear a 32-bit accumulator and 4-bit counter, and enter MUL at that edge; busy=1 from the next cycle.
REQ-020 In MUL, each edge SHALL process one multiplier bit (unsigned shift-add), LSB first; after the 16th MUL edge the FSM SHALL return to IDLE.
REQ-021 MUL completion edge SHALL load result=product[15:0], overflow=(product[31:16]!=0), zero=(product[15:0]==0), and assert valid for one cycle; busy SHALL deassert in the same cycle valid asserts.
REQ-022 MUL latency: valid high in the 16th cycle after the start edge; busy high for exactly 16 cycles.
REQ-023 start while busy=1 SHALL be ignored; inputs alu_ctrl/op_a/op_b SHALL have no effect during MUL.
REQ-024 result, zero, overflow SHALL hold their last values whenever valid=0.
REQ-025 Back-to-back single-cycle issues (start held high in IDLE) SHALL produce one valid pulse per cycle.

Reset
REQ-026 reset=1 at an edge SHALL force state IDLE, result=0x0000, zero=0, overflow=0, valid=0, busy=0, accumulator and counter=0.
REQ-027 reset SHALL take priority over start at the same edge.
REQ-028 reset during MUL SHALL abort the operation; no valid pulse for it SHALL ever occur.

Verification
REQ-029 ADD op_a=0x7FFF, op_b=0x0001 -> next cycle valid=1, result=0x8000, overflow=1, zero=0.
REQ-030 SUB 0x1234-0x1234 -> result=0x0000, zero=1, overflow=0; SUB 0x8000-0x0001 -> result=0x7FFF, overflow=1.
REQ-031 SLT op_a=0xFFFF, op_b=0x0001 -> result=0x0001; SLL op_a=0x0001, op_b=0x0013 -> result=0x0008; SRL op_a=0x8000, op_b=0x000F -> result=0x0001.
REQ-032 MUL 0x0012*0x0034 -> busy=1 for 16 cycles, valid in 16th cycle, result=0x03A8, overflow=0; MUL 0x0100*0x0100 -> result=0x0000, zero=1, overflow=1.
REQ-033 start=1 with ADD at cycle 5 of a MUL -> ignored; only the MUL valid pulse appears, result from MUL.
REQ-034 reset asserted at cycle 8 of a MUL -> next cycle busy=0, all outputs 0, no valid for 20 following idle cycles.

Source files
------------

// File: rtl/ex_alu.sv
// EX-stage ALU: single-cycle ADD/SUB/AND/OR/SLT/SLL/SRL and a 16-cycle
// unsigned shift-add multiplier. While the multiplier runs, busy stalls the pipeline.
module ex_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             valid,
  output logic             busy
);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_SLT = 3'b100, OP_SLL = 3'b101, OP_SRL = 3'b110, OP_MUL = 3'b111
  } op_t;

  state_t               state, next_state;
  op_t                  op;
  logic [WIDTH-1:0]     sum, diff, alu_res;
  logic                 alu_ovf;
  logic [WIDTH-1:0]     mul_a, mul_b;
  logic [2*WIDTH-1:0]   acc, acc_next;
  logic [3:0]           cnt;
  logic                 mul_last;

  assign op       = op_t'(alu_ctrl);
  assign busy     = (state == S_MUL);
  assign mul_last = (cnt == 4'hF);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sum     = op_a + op_b;
    diff    = op_a - op_b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLL:  alu_res = op_a << op_b[3:0];
      OP_SRL:  alu_res = op_a >> op_b[3:0];
      default: alu_res = '0;
    endcase
  end

  // One multiplier bit per cycle, LSB first: add the shifted multiplicand when set.
  always_comb begin
    acc_next = acc;
    if (mul_b[cnt]) acc_next = acc + ({{WIDTH{1'b0}}, mul_a} << cnt);
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start && op == OP_MUL) next_state = S_MUL;
      S_MUL:   if (mul_last) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous, so it only acts inside the clocked branch and wins over start.
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      valid    <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && op == OP_MUL) begin
            mul_a <= op_a;
            mul_b <= op_b;
            acc   <= '0;
            cnt   <= '0;
          end else if (start) begin
            result   <= alu_res;
            zero     <= (alu_res == '0);
            overflow <= alu_ovf;
            valid    <= 1'b1;
          end
        end
        S_MUL: begin
          acc <= acc_next;
          cnt <= cnt + 4'd1;
          if (mul_last) begin
            result   <= acc_next[WIDTH-1:0];
            overflow <= |acc_next[2*WIDTH-1:WIDTH];
            zero     <= (acc_next[WIDTH-1:0] == '0);
            valid    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu.sv
// Directed bench for ex_alu. Inputs change and outputs are sampled on the
// falling edge; each check compares {valid,busy,zero,overflow,result}.
module tb_ex_alu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  alu_ctrl = 3'b000;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [15:0] result;
  logic        zero, overflow, valid, busy;

  int passed = 0;
  int total  = 0;

  ex_alu #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .result(result), .zero(zero),
    .overflow(overflow), .valid(valid), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [19:0] obs;
  assign obs = {valid, busy, zero, overflow, result};

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         SLT = 3'b100, SLL = 3'b101, SRL = 3'b110, MUL = 3'b111;

  // Drive one single-cycle issue and land on the falling edge after it.
  task automatic issue(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    alu_ctrl = c; op_a = a; op_b = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clock); @(negedge clock);
    total++; if (obs !== 20'h0) $display("FAIL reset_state got %h exp %h", obs, 20'h0); else passed++;
    // reset wins over a simultaneous start
    reset = 1'b1; issue(ADD, 16'h0001, 16'h0001);
    total++; if (obs !== 20'h0) $display("FAIL reset_prio got %h exp %h", obs, 20'h0); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_addsub;
    issue(ADD, 16'h7FFF, 16'h0001);
    total++; if (obs !== 20'h98000) $display("FAIL add_ovf got %h exp %h", obs, 20'h98000); else passed++;
    @(negedge clock);
    total++; if (obs !== 20'h18000) $display("FAIL hold got %h exp %h", obs, 20'h18000); else passed++;
    issue(ADD, 16'h0001, 16'h0002);
    total++; if (obs !== 20'h80003) $display("FAIL add_small got %h exp %h", obs, 20'h80003); else passed++;
    issue(SUB, 16'h1234, 16'h1234);
    total++; if (obs !== 20'hA0000) $display("FAIL sub_zero got %h exp %h", obs, 20'hA0000); else passed++;
    issue(SUB, 16'h8000, 16'h0001);
    total++; if (obs !== 20'h97FFF) $display("FAIL sub_ovf got %h exp %h", obs, 20'h97FFF); else passed++;
  endtask

  task automatic test_logic_shift;
    issue(AND_, 16'hF0F0, 16'h3C3C);
    total++; if (obs !== 20'h83030) $display("FAIL and got %h exp %h", obs, 20'h83030); else passed++;
    issue(OR_, 16'hF0F0, 16'h0F0F);
    total++; if (obs !== 20'h8FFFF) $display("FAIL or got %h exp %h", obs, 20'h8FFFF); else passed++;
    issue(SLT, 16'hFFFF, 16'h0001);
    total++; if (obs !== 20'h80001) $display("FAIL slt_true got %h exp %h", obs, 20'h80001); else passed++;
    issue(SLT, 16'h0001, 16'hFFFF);
    total++; if (obs !== 20'hA0000) $display("FAIL slt_false got %h exp %h", obs, 20'hA0000); else passed++;
    issue(SLL, 16'h0001, 16'h0013);
    total++; if (obs !== 20'h80008) $display("FAIL sll got %h exp %h", obs, 20'h80008); else passed++;
    issue(SRL, 16'h8000, 16'h000F);
    total++; if (obs !== 20'h80001) $display("FAIL srl got %h exp %h", obs, 20'h80001); else passed++;
    issue(SRL, 16'h8000, 16'h0010);
    total++; if (obs !== 20'h88000) $display("FAIL srl_upper_ignored got %h exp %h", obs, 20'h88000); else passed++;
  endtask

  task automatic test_mul;
    logic [15:0] va [2] = '{16'h0012, 16'h0100};
    logic [15:0] vb [2] = '{16'h0034, 16'h0100};
    logic [19:0] ve [2] = '{20'h803A8, 20'hB0000};
    logic [19:0] vh [2] = '{20'h003A8, 20'h30000};
    for (int v = 0; v < 2; v++) begin
      issue(MUL, va[v], vb[v]);
      for (int i = 1; i <= 16; i++) begin
        total++;
        if (busy !== 1'b1 || valid !== 1'b0)
          $display("FAIL mul%0d_busy cycle %0d got busy=%b valid=%b exp busy=1 valid=0", v, i, busy, valid);
        else passed++;
        @(negedge clock);
      end
      total++; if (obs !== ve[v]) $display("FAIL mul%0d_done got %h exp %h", v, obs, ve[v]); else passed++;
      @(negedge clock);
      total++; if (obs !== vh[v]) $display("FAIL mul%0d_hold got %h exp %h", v, obs, vh[v]); else passed++;
    end
  endtask

  task automatic test_mul_ignore_start;
    int pulses = 0;
    issue(MUL, 16'h0003, 16'h0005);
    for (int i = 1; i <= 16; i++) begin
      if (valid) pulses++;
      start = (i == 5);
      alu_ctrl = ADD; op_a = 16'h0001; op_b = 16'h0001;
      @(negedge clock);
    end
    start = 1'b0;
    total++; if (pulses !== 0) $display("FAIL mul_ign_early_valid got %0d exp 0", pulses); else passed++;
    total++; if (obs !== 20'h8000F) $display("FAIL mul_ign_done got %h exp %h", obs, 20'h8000F); else passed++;
    @(negedge clock);
    total++; if (obs !== 20'h0000F) $display("FAIL mul_ign_after got %h exp %h", obs, 20'h0000F); else passed++;
  endtask

  task automatic test_mul_reset;
    int pulses = 0;
    issue(MUL, 16'hFFFF, 16'hFFFF);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++; if (obs !== 20'h0) $display("FAIL mul_abort got %h exp %h", obs, 20'h0); else passed++;
    for (int i = 0; i < 20; i++) begin
      if (valid || busy) pulses++;
      @(negedge clock);
    end
    total++; if (pulses !== 0) $display("FAIL mul_abort_idle got %0d exp 0", pulses); else passed++;
  endtask

  task automatic test_back_to_back;
    alu_ctrl = ADD; op_a = 16'h0001; op_b = 16'h0002; start = 1'b1;
    @(negedge clock);
    total++; if (obs !== 20'h80003) $display("FAIL b2b_0 got %h exp %h", obs, 20'h80003); else passed++;
    alu_ctrl = SUB; op_a = 16'h0005; op_b = 16'h0007;
    @(negedge clock);
    total++; if (obs !== 20'h8FFFE) $display("FAIL b2b_1 got %h exp %h", obs, 20'h8FFFE); else passed++;
    alu_ctrl = OR_; op_a = 16'h00F0; op_b = 16'h000F;
    @(negedge clock);
    total++; if (obs !== 20'h800FF) $display("FAIL b2b_2 got %h exp %h", obs, 20'h800FF); else passed++;
    start = 1'b0;
    @(negedge clock);
    total++; if (obs !== 20'h000FF) $display("FAIL b2b_end got %h exp %h", obs, 20'h000FF); else passed++;
  endtask

  initial begin
    test_reset;
    test_addsub;
    test_logic_shift;
    test_mul;
    test_mul_ignore_start;
    test_back_to_back;
    test_mul_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
